reg_file_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/reg_file_mp.sv | 136 +++++++++++++
 tb/tb_reg_file_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default widths and the init-value helper for the multi-port register file.
package regfile_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_e;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 4;
   localparam int DEF_NUM_REGS = 15;

   // Mode 1 seeds each register with its own index; the caller resizes to DATA_W.
   function automatic logic [63:0] init_value(input int mode, input logic [31:0] idx);
      if (mode == 1) begin
         return {32'd0, idx};
      end
      return 64'd0;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when its write arrives.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_set_en,
   input  logic [ADDR_W-1:0]        i_set_addr,
   input  logic                     i_clr0_en,
   input  logic [ADDR_W-1:0]        i_clr0_addr,
   input  logic                     i_clr1_en,
   input  logic [ADDR_W-1:0]        i_clr1_addr,
   input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
   output logic [NUM_RD-1:0]        o_rd_busy
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_next;

   genvar gi;

   // A set on the same cycle as a clear belongs to a newer producer, so it wins.
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
         logic w_set_hit;
         logic w_clr_hit;

         assign w_set_hit = i_set_en && (i_set_addr == ADDR_W'(gi));
         assign w_clr_hit = (i_clr0_en && (i_clr0_addr == ADDR_W'(gi))) ||
                            (i_clr1_en && (i_clr1_addr == ADDR_W'(gi)));
         assign w_busy_next[gi] = w_set_hit ? 1'b1 :
                                  w_clr_hit ? 1'b0 : r_busy[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
         logic [ADDR_W-1:0] w_addr;

         assign w_addr        = i_rd_addr[gi*ADDR_W +: ADDR_W];
         assign o_rd_busy[gi] = ({1'b0, w_addr} < LIMIT) ? r_busy[w_addr] : 1'b0;
      end
   endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, same-cycle bypass,
// busy scoreboard, and a sequential init engine so the array itself needs no reset.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int NUM_RD    = 2,
   parameter int INIT_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     busy_set_en,
   input  logic [ADDR_W-1:0]        busy_set_addr,
   output logic                     ready
);

   localparam int              CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(NUM_REGS);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_REGS - 1);

   rf_state_e          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic [DATA_W-1:0]  r_mem [NUM_REGS];

   logic               w_wr0_ok;
   logic               w_wr1_ok;
   logic               w_wr0_land;
   logic               w_set_ok;
   logic [DATA_W-1:0]  w_init_val;

   assign w_wr1_ok   = r_ready && wr1_en && ({1'b0, wr1_addr} < LIMIT);
   assign w_wr0_ok   = r_ready && wr0_en && ({1'b0, wr0_addr} < LIMIT);
   assign w_wr0_land = w_wr0_ok && !(w_wr1_ok && (wr1_addr == wr0_addr));
   assign w_set_ok   = r_ready && busy_set_en && ({1'b0, busy_set_addr} < LIMIT);
   assign w_init_val = DATA_W'(init_value(INIT_MODE, 32'(r_cnt)));

   assign ready = r_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end
            end
            RUN: begin
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= INIT;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Storage carries no reset; the init engine walks every entry instead.
   always_ff @(posedge clk) begin
      if (r_state == INIT) begin
         r_mem[r_cnt[ADDR_W-1:0]] <= w_init_val;
      end else begin
         if (w_wr1_ok) begin
            r_mem[wr1_addr] <= wr1_data;
         end
         if (w_wr0_land) begin
            r_mem[wr0_addr] <= wr0_data;
         end
      end
   end

   genvar gi;

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic              w_in_range;
         logic [DATA_W-1:0] w_val;

         assign w_addr     = rd_addr[gi*ADDR_W +: ADDR_W];
         assign w_in_range = ({1'b0, w_addr} < LIMIT);

         always_comb begin
            w_val = '0;
            if (r_ready && w_in_range) begin
               if (w_wr1_ok && (wr1_addr == w_addr)) begin
                  w_val = wr1_data;
               end else if (w_wr0_ok && (wr0_addr == w_addr)) begin
                  w_val = wr0_data;
               end else begin
                  w_val = r_mem[w_addr];
               end
            end
         end

         assign rd_data[gi*DATA_W +: DATA_W] = w_val;
      end
   endgenerate

   // A dropped wr0 still retires its producer, so both ports feed the clear.
   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst),
      .i_set_en    (w_set_ok),
      .i_set_addr  (busy_set_addr),
      .i_clr0_en   (w_wr0_ok),
      .i_clr0_addr (wr0_addr),
      .i_clr1_en   (w_wr1_ok),
      .i_clr1_addr (wr1_addr),
      .i_rd_addr   (rd_addr),
      .o_rd_busy   (rd_busy)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: the driver queues expected values, a monitor compares them.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic              wr0_en;
   logic [AW-1:0]     wr0_addr;
   logic [DW-1:0]     wr0_data;
   logic              wr1_en;
   logic [AW-1:0]     wr1_addr;
   logic [DW-1:0]     wr1_data;
   logic              busy_set_en;
   logic [AW-1:0]     busy_set_addr;
   logic              ready;

   always #5 clk = ~clk;

   reg_file_mp #(
      .DATA_W    (DW),
      .NUM_REGS  (15),
      .ADDR_W    (AW),
      .NUM_RD    (NR),
      .INIT_MODE (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_busy       (rd_busy),
      .wr0_en        (wr0_en),
      .wr0_addr      (wr0_addr),
      .wr0_data      (wr0_data),
      .wr1_en        (wr1_en),
      .wr1_addr      (wr1_addr),
      .wr1_data      (wr1_data),
      .busy_set_en   (busy_set_en),
      .busy_set_addr (busy_set_addr),
      .ready         (ready)
   );

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   event mon_ev;

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         0:       return {31'd0, ready};
         1:       return rd_data[31:0];
         2:       return rd_data[63:32];
         default: return {30'd0, rd_busy};
      endcase
   endfunction

   initial begin
      forever begin
         @(negedge clk or mon_ev);
         while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = observe(e.kind);
            checks++;
            if (act !== e.exp) begin
               failures++;
               $display("FAIL %s: actual=0x%0h required=0x%0h", e.name, act, e.exp);
            end else begin
               $display("ok   %s: 0x%0h", e.name, act);
            end
         end
      end
   end

   task automatic push(input string n, input int k, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.kind = k;
      e.exp  = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_rd(input string n, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic r);
      push({n, ".ready"}, 0, {31'd0, r});
      push({n, ".d0"},    1, d0);
      push({n, ".d1"},    2, d1);
      push({n, ".busy"},  3, {30'd0, b});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr0_en      = 1'b0;
      wr1_en      = 1'b0;
      busy_set_en = 1'b0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic do_wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr0_en   = 1'b1;
      wr0_addr = a;
      wr0_data = d;
   endtask

   task automatic do_wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr1_en   = 1'b1;
      wr1_addr = a;
      wr1_data = d;
   endtask

   task automatic do_set(input logic [AW-1:0] a);
      busy_set_en   = 1'b1;
      busy_set_addr = a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] exp_mem [16];

   initial begin
      rst = 1'b0;
      idle();
      wr0_addr = '0; wr0_data = '0;
      wr1_addr = '0; wr1_data = '0;
      busy_set_addr = '0;
      set_rd(4'd0, 4'd0);

      step();
      expect_rd("reset", 32'h0, 32'h0, 2'b00, 1'b0);
      step();
      rst = 1'b1;

      // Fifteen cycles of INIT; a write and a busy_set issued mid-init must be ignored.
      for (int i = 0; i < 15; i++) begin
         idle();
         set_rd(4'd3, 4'd14);
         if (i == 2) begin
            do_wr0(4'd5, 32'hDEAD);
            do_set(4'd6);
         end
         expect_rd($sformatf("init%0d", i), 32'h0, 32'h0, 2'b00, 1'b0);
         step();
      end
      idle();
      expect_rd("post_init", 32'h3, 32'hE, 2'b00, 1'b1);
      step();
      set_rd(4'd5, 4'd6);
      expect_rd("init_wr_ignored", 32'h5, 32'h6, 2'b00, 1'b1);
      step();

      do_wr0(4'd7, 32'h11);
      do_wr1(4'd7, 32'h22);
      set_rd(4'd7, 4'd7);
      expect_rd("prio_bypass", 32'h22, 32'h22, 2'b00, 1'b1);
      step();
      idle();
      expect_rd("prio_stored", 32'h22, 32'h22, 2'b00, 1'b1);
      step();
      do_wr0(4'd7, 32'h33);
      expect_rd("wr0_bypass", 32'h33, 32'h33, 2'b00, 1'b1);
      step();
      idle();
      set_rd(4'd7, 4'd0);
      expect_rd("wr0_stored", 32'h33, 32'h0, 2'b00, 1'b1);
      step();
      do_wr0(4'd8, 32'h88);
      do_wr1(4'd9, 32'h99);
      set_rd(4'd8, 4'd9);
      expect_rd("dual_bypass", 32'h88, 32'h99, 2'b00, 1'b1);
      step();
      idle();
      expect_rd("dual_stored", 32'h88, 32'h99, 2'b00, 1'b1);
      step();

      do_set(4'd4);
      set_rd(4'd4, 4'd9);
      expect_rd("set_same_cycle", 32'h4, 32'h99, 2'b00, 1'b1);
      step();
      idle();
      expect_rd("set_next", 32'h4, 32'h99, 2'b01, 1'b1);
      step();
      do_wr0(4'd4, 32'h44);
      expect_rd("clr_same_cycle", 32'h44, 32'h99, 2'b01, 1'b1);
      step();
      idle();
      expect_rd("clr_next", 32'h44, 32'h99, 2'b00, 1'b1);
      step();
      do_set(4'd4);
      do_wr1(4'd4, 32'h45);
      set_rd(4'd4, 4'd4);
      expect_rd("set_vs_clr", 32'h45, 32'h45, 2'b00, 1'b1);
      step();
      idle();
      expect_rd("set_wins", 32'h45, 32'h45, 2'b11, 1'b1);
      step();
      do_wr0(4'd4, 32'h50);
      do_wr1(4'd4, 32'h51);
      expect_rd("dual_clr_bypass", 32'h51, 32'h51, 2'b11, 1'b1);
      step();
      idle();
      expect_rd("dual_clr_next", 32'h51, 32'h51, 2'b00, 1'b1);
      step();

      do_wr0(4'd15, 32'hFF);
      do_set(4'd15);
      set_rd(4'd15, 4'd15);
      expect_rd("oor_same_cycle", 32'h0, 32'h0, 2'b00, 1'b1);
      step();
      idle();
      expect_rd("oor_next", 32'h0, 32'h0, 2'b00, 1'b1);
      step();

      // Hand-derived contents after the writes above; entry 15 is out of range and reads 0.
      for (int a = 0; a < 16; a++) exp_mem[a] = 32'(a);
      exp_mem[4]  = 32'h51;
      exp_mem[7]  = 32'h33;
      exp_mem[8]  = 32'h88;
      exp_mem[9]  = 32'h99;
      exp_mem[15] = 32'h0;
      for (int a = 0; a < 16; a += 2) begin
         set_rd(4'(a), 4'(a + 1));
         expect_rd($sformatf("scan%0d", a), exp_mem[a], exp_mem[a + 1], 2'b00, 1'b1);
         step();
      end

      do_wr0(4'd2, 32'hABCD);
      step();
      idle();
      do_set(4'd2);
      set_rd(4'd2, 4'd2);
      expect_rd("pre_rst_wr", 32'hABCD, 32'hABCD, 2'b00, 1'b1);
      step();
      idle();
      expect_rd("pre_rst_busy", 32'hABCD, 32'hABCD, 2'b11, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      expect_rd("async_rst", 32'h0, 32'h0, 2'b00, 1'b0);
      ->mon_ev;
      step();
      rst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         expect_rd($sformatf("reinit%0d", i), 32'h0, 32'h0, 2'b00, 1'b0);
         step();
      end
      set_rd(4'd2, 4'd4);
      expect_rd("after_reinit", 32'h2, 32'h4, 2'b00, 1'b1);
      step();

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
